// File: rtl/umstr_udp_pkg.sv
// Shared types and helpers for the UDP header insertion stage.
// Checksum hardware is built only when UMSTR_UDP_CSUM_EN is defined.
package umstr_udp_pkg;

   localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
   localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

   typedef enum logic [2:0] {IDLE, CALC, HDR0, HDR1, DATA} udp_ins_state_t;

   // Two end-around-carry folds are enough to bring a 20-bit sum to 16 bits.
   function automatic logic [15:0] csum_fold(input logic [19:0] s);
      logic [16:0] f1;
      logic [16:0] f2;
      f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
      f2 = {1'b0, f1[15:0]} + {16'd0, f1[16]};
      return f2[15:0];
   endfunction

endpackage

// File: rtl/umstr_udp_csum_calc.sv
// Registered UDP checksum: pseudo-header + UDP header + payload sum, folded and inverted.
// Instantiated by umstr_udp_hdr_insert only when UMSTR_UDP_CSUM_EN is defined.
module umstr_udp_csum_calc
   import umstr_udp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ip_src,
   input  logic [31:0] ip_dst,
   input  logic [15:0] port_src,
   input  logic [15:0] port_dst,
   input  logic [15:0] udp_len,
   input  logic [15:0] data_csum,
   output logic [15:0] csum
);

   logic [19:0] sum;
   logic [15:0] inv;

   // udp_len appears twice: once in the pseudo-header, once in the UDP header itself.
   always_comb begin
      sum = 20'(ip_src[31:16]) + 20'(ip_src[15:0]) + 20'(ip_dst[31:16]) + 20'(ip_dst[15:0])
          + 20'(IP_PROTO_UDP) + {3'd0, udp_len, 1'b0} + 20'(port_src) + 20'(port_dst)
          + 20'(data_csum);
      inv = ~csum_fold(sum);
   end

   // An all-zero checksum means "none" on the wire, so send its 1's-complement twin.
   always_ff @(posedge clk) begin
      if (reset) csum <= '0;
      else       csum <= (inv == 16'h0000) ? 16'hFFFF : inv;
   end

endmodule

// File: rtl/umstr_udp_hdr_insert.sv
// Prepends the 8-byte UDP header to a 32-bit payload stream and forwards IP addresses/length.
// UMSTR_UDP_CSUM_EN: defined -> real checksum; undefined -> checksum field 16'h0000.
module umstr_udp_hdr_insert
   import umstr_udp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] hdr_ip_dest_i,
   input  logic [31:0] hdr_ip_src_i,
   input  logic [15:0] hdr_port_dest_i,
   input  logic [15:0] hdr_port_src_i,
   input  logic [15:0] user_data_csum_i,
   input  logic [15:0] user_data_len_i,
   input  logic [31:0] user_tdata_i,
   input  logic        user_tvld_i,
   input  logic        user_tlast_i,
   input  logic [3:0]  user_tkeep_i,
   output logic        user_trdy_o,
   output logic [31:0] hdr_ip_dest_o,
   output logic [31:0] hdr_ip_src_o,
   output logic [15:0] udp_len_o,
   output logic [31:0] udp_tdata_o,
   output logic        udp_tvld_o,
   output logic        udp_tlast_o,
   output logic [3:0]  udp_tkeep_o,
   input  logic        udp_trdy_i
);

   udp_ins_state_t state, state_nxt;
   logic [15:0]    port_src_q;
   logic [15:0]    port_dst_q;
   logic [15:0]    udp_csum;
   logic           in_done;
   logic           in_hs;
   logic           out_hs;

   assign out_hs = udp_tvld_o & udp_trdy_i;
   assign in_hs  = user_tvld_i & user_trdy_o;
   // in_done stops the next packet's first word being swallowed while the tail drains.
   assign user_trdy_o = (state == DATA) && !in_done && (!udp_tvld_o || udp_trdy_i);

`ifdef UMSTR_UDP_CSUM_EN
   logic [15:0] data_csum_q;

   always_ff @(posedge clk) begin
      if (reset)                            data_csum_q <= '0;
      else if (state == IDLE && user_tvld_i) data_csum_q <= user_data_csum_i;
   end

   umstr_udp_csum_calc u_csum (
      .clk       (clk),
      .reset     (reset),
      .ip_src    (hdr_ip_src_o),
      .ip_dst    (hdr_ip_dest_o),
      .port_src  (port_src_q),
      .port_dst  (port_dst_q),
      .udp_len   (udp_len_o),
      .data_csum (data_csum_q),
      .csum      (udp_csum)
   );
`else
   logic unused_csum_in;
   assign unused_csum_in = ^user_data_csum_i;
   assign udp_csum       = 16'h0000;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (user_tvld_i) state_nxt = CALC;
         CALC:    state_nxt = HDR0;
         HDR0:    if (out_hs) state_nxt = HDR1;
         HDR1:    if (out_hs) state_nxt = DATA;
         DATA:    if (out_hs && udp_tlast_o) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_ip_dest_o <= '0;
         hdr_ip_src_o  <= '0;
         udp_len_o     <= '0;
         port_src_q    <= '0;
         port_dst_q    <= '0;
         in_done       <= 1'b0;
         udp_tdata_o   <= '0;
         udp_tvld_o    <= 1'b0;
         udp_tlast_o   <= 1'b0;
         udp_tkeep_o   <= '0;
      end else begin
         case (state)
            IDLE: if (user_tvld_i) begin
               hdr_ip_dest_o <= hdr_ip_dest_i;
               hdr_ip_src_o  <= hdr_ip_src_i;
               udp_len_o     <= user_data_len_i + UDP_HDR_LEN;
               port_src_q    <= hdr_port_src_i;
               port_dst_q    <= hdr_port_dest_i;
               in_done       <= 1'b0;
            end
            CALC: begin
               udp_tvld_o  <= 1'b1;
               udp_tdata_o <= {port_src_q, port_dst_q};
               udp_tkeep_o <= 4'hF;
               udp_tlast_o <= 1'b0;
            end
            HDR0: if (out_hs) udp_tdata_o <= {udp_len_o, udp_csum};
            HDR1: if (out_hs) udp_tvld_o <= 1'b0;
            DATA: begin
               if (in_hs) begin
                  udp_tvld_o  <= 1'b1;
                  udp_tdata_o <= user_tdata_i;
                  udp_tkeep_o <= user_tkeep_i;
                  udp_tlast_o <= user_tlast_i;
                  if (user_tlast_i) in_done <= 1'b1;
               end else if (out_hs) begin
                  udp_tvld_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_umstr_udp_hdr_insert.sv
// Directed + random-backpressure bench for umstr_udp_hdr_insert against a queue-based datagram model.
`timescale 1ns/1ps
module tb_umstr_udp_hdr_insert;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] hdr_ip_dest_i = '0, hdr_ip_src_i = '0;
   logic [15:0] hdr_port_dest_i = '0, hdr_port_src_i = '0;
   logic [15:0] user_data_csum_i = '0, user_data_len_i = '0;
   logic [31:0] user_tdata_i = '0;
   logic        user_tvld_i = 1'b0, user_tlast_i = 1'b0;
   logic [3:0]  user_tkeep_i = '0;
   logic        user_trdy_o;
   logic [31:0] hdr_ip_dest_o, hdr_ip_src_o;
   logic [15:0] udp_len_o;
   logic [31:0] udp_tdata_o;
   logic        udp_tvld_o, udp_tlast_o;
   logic [3:0]  udp_tkeep_o;
   logic        udp_trdy_i = 1'b1;

   always #5 clk = ~clk;

   umstr_udp_hdr_insert dut (
      .clk(clk), .reset(reset),
      .hdr_ip_dest_i(hdr_ip_dest_i), .hdr_ip_src_i(hdr_ip_src_i),
      .hdr_port_dest_i(hdr_port_dest_i), .hdr_port_src_i(hdr_port_src_i),
      .user_data_csum_i(user_data_csum_i), .user_data_len_i(user_data_len_i),
      .user_tdata_i(user_tdata_i), .user_tvld_i(user_tvld_i), .user_tlast_i(user_tlast_i),
      .user_tkeep_i(user_tkeep_i), .user_trdy_o(user_trdy_o),
      .hdr_ip_dest_o(hdr_ip_dest_o), .hdr_ip_src_o(hdr_ip_src_o), .udp_len_o(udp_len_o),
      .udp_tdata_o(udp_tdata_o), .udp_tvld_o(udp_tvld_o), .udp_tlast_o(udp_tlast_o),
      .udp_tkeep_o(udp_tkeep_o), .udp_trdy_i(udp_trdy_i)
   );

   typedef struct { logic [31:0] d; logic [3:0] k; logic l; } wrd_t;
   typedef struct { logic [31:0] dst; logic [31:0] src; logic [15:0] len; } meta_t;

   wrd_t        exp_q[$];
   meta_t       meta_q[$];
   wrd_t        log_q[$];
   logic [7:0]  pl[$];
   int          chk_cnt = 0;
   int          pass_cnt = 0;
   logic        rnd_rdy = 1'b0;

`ifdef UMSTR_UDP_CSUM_EN
   localparam logic [31:0] T1_W1 = 32'h000C7838;
   localparam logic [31:0] T2_W1 = 32'h000CFFFF;
`else
   localparam logic [31:0] T1_W1 = 32'h000C0000;
   localparam logic [31:0] T2_W1 = 32'h000C0000;
`endif

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // Non-inverted 1's-complement sum of the payload, odd byte padded with zero.
   function automatic logic [15:0] pay_csum();
      int unsigned a = 0;
      for (int i = 0; i < pl.size(); i += 2)
         a += {pl[i], (i + 1 < pl.size()) ? pl[i+1] : 8'h00};
      while (a > 32'hFFFF) a = (a & 32'hFFFF) + (a >> 16);
      return a[15:0];
   endfunction

   function automatic logic [15:0] exp_csum(input logic [31:0] s, input logic [31:0] d,
                                            input logic [15:0] sp, input logic [15:0] dp,
                                            input logic [15:0] ul, input logic [15:0] ci);
`ifdef UMSTR_UDP_CSUM_EN
      int unsigned a;
      logic [15:0] c;
      a = 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]) + 32'd17
        + 32'(ul) * 2 + 32'(sp) + 32'(dp) + 32'(ci);
      while (a > 32'hFFFF) a = (a & 32'hFFFF) + (a >> 16);
      c = ~a[15:0];
      return (c == 16'h0000) ? 16'hFFFF : c;
`else
      return 16'h0000 & (s[15:0] ^ d[15:0] ^ sp ^ dp ^ ul ^ ci);
`endif
   endfunction

   function automatic wrd_t word_of(input int k);
      wrd_t w;
      int n = pl.size();
      w.d = '0; w.k = '0;
      for (int b = 0; b < 4; b++)
         if (4*k + b < n) begin
            w.d[31-8*b -: 8] = pl[4*k+b];
            w.k[3-b] = 1'b1;
         end
      w.l = (k == (n + 3) / 4 - 1);
      return w;
   endfunction

   // Model push + drive; abort_after>0 pulses reset after that many input words.
   task automatic send_pkt(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] sp, input logic [15:0] dp, input int abort_after);
      int n, nw, t;
      logic [15:0] ci, ul;
      meta_t m;
      wrd_t w;
      n = pl.size(); nw = (n + 3) / 4;
      ci = pay_csum(); ul = 16'(n + 8);
      m.dst = dst; m.src = src; m.len = ul;
      meta_q.push_back(m);
      w.d = {sp, dp}; w.k = 4'hF; w.l = 1'b0; exp_q.push_back(w);
      w.d = {ul, exp_csum(src, dst, sp, dp, ul, ci)}; exp_q.push_back(w);
      for (int k = 0; k < nw; k++) exp_q.push_back(word_of(k));
      hdr_ip_src_i = src; hdr_ip_dest_i = dst; hdr_port_src_i = sp; hdr_port_dest_i = dp;
      user_data_csum_i = ci; user_data_len_i = 16'(n);
      for (int k = 0; k < nw; k++) begin
         w = word_of(k);
         user_tdata_i = w.d; user_tkeep_i = w.k; user_tlast_i = w.l; user_tvld_i = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!user_trdy_o && t < 3000);
         if (!user_trdy_o) begin
            chk("input_handshake_timeout", 96'(t), 96'd0);
            $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
            $finish;
         end
         @(posedge clk); #1;
         if (k + 1 == abort_after) begin
            reset = 1'b1; user_tvld_i = 1'b0;
            exp_q.delete(); meta_q.delete();
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
      end
      user_tvld_i = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
      chk("drain_remaining_words", 96'(exp_q.size()), 96'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk); #1;
      udp_trdy_i = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Compare process: every handshaken word against the model, plus stall stability.
   initial begin
      logic        prev_stall;
      logic [36:0] prev_word;
      wrd_t        e, a;
      prev_stall = 1'b0; prev_word = '0;
      forever begin
         @(negedge clk);
         if (reset) prev_stall = 1'b0;
         else begin
            if (prev_stall)
               chk("stall_hold", {udp_tvld_o, udp_tlast_o, udp_tkeep_o, udp_tdata_o}, {1'b1, prev_word});
            if (udp_tvld_o && udp_trdy_i) begin
               a.d = udp_tdata_o; a.k = udp_tkeep_o; a.l = udp_tlast_o;
               log_q.push_back(a);
               if (exp_q.size() == 0) chk("spurious_word", 96'(exp_q.size()), 96'd1);
               else begin
                  e = exp_q.pop_front();
                  chk("out_word", {udp_tlast_o, udp_tkeep_o, udp_tdata_o}, {e.l, e.k, e.d});
                  if (meta_q.size() != 0) begin
                     chk("ip_len_out", {hdr_ip_dest_o, hdr_ip_src_o, udp_len_o},
                         {meta_q[0].dst, meta_q[0].src, meta_q[0].len});
                     if (e.l) void'(meta_q.pop_front());
                  end
               end
            end
            prev_stall = udp_tvld_o && !udp_trdy_i;
            prev_word  = {udp_tlast_o, udp_tkeep_o, udp_tdata_o};
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_trdy",   96'(user_trdy_o), 96'd0);
      chk("rst_tvld",   96'(udp_tvld_o),  96'd0);
      chk("rst_tdata",  96'(udp_tdata_o), 96'd0);
      chk("rst_ip_len", {hdr_ip_dest_o, hdr_ip_src_o, udp_len_o}, 96'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: basic datagram, with header latched this cycle -> word0 valid two cycles later
      log_q.delete();
      pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      fork
         send_pkt(32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, -1);
         begin
            @(negedge clk); chk("lat_n",   96'(udp_tvld_o), 96'd0);
            @(negedge clk); chk("lat_n1",  96'(udp_tvld_o), 96'd0);
            @(negedge clk); chk("lat_n2",  96'(udp_tvld_o), 96'd1);
         end
      join
      drain();
      chk("t1_count", 96'(log_q.size()), 96'd3);
      if (log_q.size() >= 3) begin
         chk("t1_word0", 96'(log_q[0].d), 96'h12345678);
         chk("t1_word1", 96'(log_q[1].d), 96'(T1_W1));
         chk("t1_word2", {log_q[2].l, log_q[2].k, log_q[2].d}, {1'b1, 4'hF, 32'hDEADBEEF});
      end
      chk("t1_udp_len", 96'(udp_len_o), 96'h000C);

      // 2: payload sum 15D6 forces a zero checksum -> FFFF on the wire
      log_q.delete();
      pl = '{8'h15, 8'hD6, 8'h00, 8'h00};
      send_pkt(32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, -1);
      drain();
      if (log_q.size() >= 2) chk("t2_word1", 96'(log_q[1].d), 96'(T2_W1));
      else chk("t2_count", 96'(log_q.size()), 96'd3);

      // 3: odd length, partial last word
      log_q.delete();
      pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
      send_pkt(32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, -1);
      drain();
      chk("t3_count", 96'(log_q.size()), 96'd4);
      if (log_q.size() >= 4) begin
         chk("t3_len_field", 96'(log_q[1].d[31:16]), 96'h000D);
         chk("t3_last_word", {log_q[3].l, log_q[3].k, log_q[3].d}, {1'b1, 4'h8, 32'h01000000});
      end

      // 4: random backpressure, back-to-back random packets
      rnd_rdy = 1'b1;
      for (int p = 0; p < 100; p++) begin
         pl.delete();
         for (int i = 0; i < $urandom_range(1, 64); i++) pl.push_back(8'($urandom));
         send_pkt($urandom, $urandom, 16'($urandom), 16'($urandom), -1);
      end
      drain();
      rnd_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 5: reset pulse mid-payload of A, then B must come out whole
      pl.delete();
      for (int i = 0; i < 20; i++) pl.push_back(8'(i * 7 + 3));
      send_pkt(32'h0A000001, 32'h0A000002, 16'h0400, 16'h0035, 2);
      @(negedge clk);
      chk("post_reset_tvld", 96'(udp_tvld_o), 96'd0);
      @(posedge clk); #1;
      log_q.delete();
      pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
      send_pkt(32'h0A000003, 32'h0A000004, 16'hABCD, 16'h0007, -1);
      drain();
      chk("t5_b_count", 96'(log_q.size()), 96'd5);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
